neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/nn_pkg.sv | 46 ++++
 rtl/neuron_act_sat.sv | 32 +++
 rtl/neuron_sequencer.sv | 102 ++++++++++
 tb/tb_neuron_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared widths, layer codes, default layer sizes and FSM state type for the
// single-neuron MAC sequencer.
package nn_pkg;

    localparam int DATA_W   = 8;
    localparam int WEIGHT_W = 8;
    localparam int BIAS_W   = 16;
    localparam int PROD_W   = 16;
    localparam int ACC_W    = 24;
    localparam int RESULT_W = 8;
    localparam int ADDR_W   = 7;

    // Q2.14 accumulator back to Q1.7
    localparam int ACT_SHIFT = 7;

    localparam logic [1:0] LAYER_L1   = 2'b00;
    localparam logic [1:0] LAYER_L2   = 2'b01;
    localparam logic [1:0] LAYER_OUT  = 2'b10;
    localparam logic [1:0] LAYER_NONE = 2'b11;

    localparam int N_L1_DEFAULT = 62;
    localparam int N_L2_DEFAULT = 10;
    localparam int N_L3_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_ACT  = 2'd3
    } seq_state_t;

    function automatic logic [ADDR_W-1:0] layer_len(
        input logic [1:0] sel,
        input int         n1,
        input int         n2,
        input int         n3
    );
        case (sel)
            LAYER_L1:  return ADDR_W'(n1);
            LAYER_L2:  return ADDR_W'(n2);
            LAYER_OUT: return ADDR_W'(n3);
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/neuron_act_sat.sv
// Activation stage: rescale the accumulator to Q1.7, optional ReLU, and
// saturate into a signed 8-bit result. Purely combinational.
module neuron_act_sat
    import nn_pkg::*;
(
    input  logic signed [ACC_W-1:0]    acc,
    input  logic                       relu_en,
    output logic signed [RESULT_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] rectified;

    always_comb begin
        shifted   = acc >>> ACT_SHIFT;
        rectified = shifted;
        if (relu_en && shifted < 0) begin
            rectified = '0;
        end

        result = rectified[RESULT_W-1:0];
        if (rectified > SAT_MAX) begin
            result = SAT_MAX[RESULT_W-1:0];
        end else if (rectified < SAT_MIN) begin
            result = SAT_MIN[RESULT_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Evaluates one neuron: streams N input/weight pairs through a MAC, adds the
// bias, then applies activation and saturation into a held result register.
module neuron_sequencer
    import nn_pkg::*;
#(
    parameter int N_L1 = N_L1_DEFAULT,
    parameter int N_L2 = N_L2_DEFAULT,
    parameter int N_L3 = N_L3_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 layer_sel,
    input  logic signed [DATA_W-1:0]   data_in,
    input  logic signed [WEIGHT_W-1:0] weight_in,
    input  logic signed [BIAS_W-1:0]   bias_in,
    output logic [ADDR_W-1:0]          addr,
    output logic                       ready,
    output logic signed [RESULT_W-1:0] result
);

    seq_state_t                 state_reg;
    seq_state_t                 state_next;
    logic [ADDR_W-1:0]          count_reg;
    logic [ADDR_W-1:0]          n_reg;
    logic [1:0]                 layer_reg;
    logic signed [ACC_W-1:0]    acc_reg;
    logic signed [RESULT_W-1:0] result_reg;

    logic                       start_ok;
    logic                       mac_last;
    logic signed [PROD_W-1:0]   product;
    logic signed [RESULT_W-1:0] act_out;

    assign start_ok = (state_reg == ST_IDLE) && start && (layer_sel != LAYER_NONE);
    assign mac_last = (count_reg == n_reg - ADDR_W'(1));
    assign product  = data_in * weight_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_ok) state_next = ST_MAC;
            ST_MAC:  if (mac_last) state_next = ST_BIAS;
            ST_BIAS: state_next = ST_ACT;
            ST_ACT:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Layer code and length are captured at start so later layer_sel changes are inert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            n_reg      <= '0;
            layer_reg  <= LAYER_NONE;
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        layer_reg <= layer_sel;
                        n_reg     <= layer_len(layer_sel, N_L1, N_L2, N_L3);
                        count_reg <= '0;
                        acc_reg   <= '0;
                    end
                end
                ST_MAC: begin
                    acc_reg   <= acc_reg + ACC_W'(product);
                    count_reg <= count_reg + ADDR_W'(1);
                end
                ST_BIAS: begin
                    acc_reg <= acc_reg + ACC_W'(bias_in);
                end
                ST_ACT: begin
                    result_reg <= act_out;
                    count_reg  <= '0;
                end
                default: ;
            endcase
        end
    end

    neuron_act_sat u_act (
        .acc     (acc_reg),
        .relu_en (layer_reg != LAYER_OUT),
        .result  (act_out)
    );

    assign addr   = (state_reg == ST_MAC) ? count_reg : '0;
    assign ready  = (state_reg == ST_IDLE);
    assign result = result_reg;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Scoreboard bench for neuron_sequencer: stimulus pushes expected results,
// a negedge monitor pops and checks them on every rising edge of ready.
module tb_neuron_sequencer;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        layer_sel = 2'b11;
    logic signed [7:0] data_in;
    logic signed [7:0] weight_in;
    logic signed [15:0] bias_in = '0;
    logic [6:0]        addr;
    logic              ready;
    logic signed [7:0] result;

    logic [7:0] data_mem   [128];
    logic [7:0] weight_mem [128];

    typedef struct {
        logic signed [7:0] res;
        int                exp_cyc;
        bit                chk_lat;
        string             name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic ready_prev = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data_in   = data_mem[addr];
    assign weight_in = weight_mem[addr];

    neuron_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .layer_sel (layer_sel),
        .data_in   (data_in),
        .weight_in (weight_in),
        .bias_in   (bias_in),
        .addr      (addr),
        .ready     (ready),
        .result    (result)
    );

    // Monitor: every completion (or reset abort) is a ready rising edge.
    always @(negedge clk) begin
        if (ready && !ready_prev) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ready: ready rose with no expected entry, result=%0d", result);
            end else begin
                mon_e = sb.pop_front();
                compared++;
                if (result !== mon_e.res) begin
                    mismatched++;
                    $display("FAIL %s_result: got %0d expected %0d", mon_e.name, result, mon_e.res);
                end else begin
                    $display("txn %s: result=%0d cycle=%0d", mon_e.name, result, cyc);
                end
                if (mon_e.chk_lat) begin
                    compared++;
                    if (cyc != mon_e.exp_cyc) begin
                        mismatched++;
                        $display("FAIL %s_latency: ready at cycle %0d expected %0d", mon_e.name, cyc, mon_e.exp_cyc);
                    end
                end
            end
        end
        ready_prev <= ready;
    end

    task automatic fill(input logic [7:0] dval, input logic [7:0] wval, input logic [15:0] bval);
        for (int i = 0; i < 128; i++) begin
            data_mem[i]   = dval;
            weight_mem[i] = wval;
        end
        bias_in = bval;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic run(input string name, input logic [1:0] sel, input logic [7:0] dval,
                       input logic [7:0] wval, input logic [15:0] bval,
                       input logic signed [7:0] exp_res, input int n,
                       input bit chk_addr, input bit mid_start);
        int  k;
        bit  done;
        int  c0;
        fill(dval, wval, bval);
        @(negedge clk);
        start = 1'b1;
        layer_sel = sel;
        @(posedge clk);
        #1;
        c0 = cyc;
        sb.push_back('{exp_res, c0 + n + 2, 1'b1, name});
        start = 1'b0;
        layer_sel = 2'b11;
        k = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else begin
                if (chk_addr) check({name, "_addr"}, 32'(addr), (k < n) ? k : 0);
                if (mid_start && k == 3) begin
                    start = 1'b1;
                    layer_sel = 2'b00;
                end else begin
                    start = 1'b0;
                    layer_sel = 2'b11;
                end
                k++;
                if (k > 300) begin
                    compared++;
                    mismatched++;
                    $display("FAIL %s_timeout: ready not seen after %0d cycles, expected %0d", name, k, n + 2);
                    done = 1'b1;
                end
            end
        end
        start = 1'b0;
        layer_sel = 2'b11;
    endtask

    initial begin
        int k;
        fill(8'h00, 8'h00, 16'h0000);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 1);
        check("reset_result", 32'(result), 0);
        check("reset_addr", 32'(addr), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run("l1_sat",   2'b00, 8'h40, 8'h40, 16'h0000, 8'sd127,  62, 1'b0, 1'b0);
        run("l2_relu",  2'b01, 8'h40, 8'hC0, 16'h0000, 8'sd0,    10, 1'b0, 1'b0);
        run("out_neg",  2'b10, 8'h40, 8'hC0, 16'h0000, -8'sd128, 10, 1'b0, 1'b0);
        run("l3_bias",  2'b10, 8'h20, 8'h20, 16'h0100, 8'sd82,   10, 1'b1, 1'b0);
        check("hold_after_act", 32'(result), 32'(8'sd82));

        // Reset in the middle of MAC at count 5
        fill(8'h40, 8'hC0, 16'h0000);
        @(negedge clk);
        start = 1'b1;
        layer_sel = 2'b10;
        @(posedge clk);
        #1;
        start = 1'b0;
        layer_sel = 2'b11;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (addr != 7'd5 && k < 50);
        check("mid_mac_reached", 32'(addr), 5);
        check("hold_during_mac", 32'(result), 32'(8'sd82));
        sb.push_back('{8'sd0, 0, 1'b0, "reset_abort"});
        #2;
        rst = 1'b1;
        #1;
        check("rst_ready", 32'(ready), 1);
        check("rst_result", 32'(result), 0);
        check("rst_addr", 32'(addr), 0);
        start = 1'b1;
        layer_sel = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        layer_sel = 2'b11;
        @(negedge clk);
        check("start_at_rst_release_ignored", 32'(ready), 1);

        run("after_reset", 2'b10, 8'h20, 8'h20, 16'h0100, 8'sd82, 10, 1'b1, 1'b0);
        run("l2_pos", 2'b01, 8'h40, 8'h40, 16'h0000, 8'sd127, 10, 1'b0, 1'b0);

        // Idle code on start is a no-op
        @(negedge clk);
        start = 1'b1;
        layer_sel = 2'b11;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_code_ignored", 32'(ready), 1);
        end
        check("idle_code_result_kept", 32'(result), 32'(8'sd127));

        // Second start mid-MAC must not disturb an L3 run
        run("mid_start", 2'b10, 8'h20, 8'h20, 16'h0100, 8'sd82, 10, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
